// File: rtl/avalon_stream_arbiter_pkg.sv
// Shared types and helpers for the packet-aware Avalon-ST arbiter.
// Optional feature macro: AVALON_STREAM_ARBITER_CHANNEL_EN (adds out_channel).
package avalon_stream_pkg;

    localparam int unsigned MAX_IN        = 16;
    localparam int unsigned MAX_IDX_WIDTH = 4;

    // Arbiter state: IDLE arbitrates, LOCKED forwards one packet from the grant.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Result of one round-robin search.
    typedef struct packed {
        logic                     found;
        logic [MAX_IDX_WIDTH-1:0] idx;
    } rr_pick_t;

    // Grant index width a given requester count needs (never below 1).
    function automatic int unsigned idx_width_for(input int unsigned num_in);
        return (num_in <= 2) ? 32'd1 : 32'($clog2(num_in));
    endfunction

    // First set request searching upward from last+1, wrapping at num_in.
    function automatic rr_pick_t rr_next(input logic [MAX_IN-1:0] req,
                                         input int unsigned        last,
                                         input int unsigned        num_in);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned k = 1; k <= MAX_IN; k++) begin
            cand = last + k;
            if (cand >= num_in) begin
                cand = cand - num_in;
            end
            if (!res.found && (k <= num_in) && req[cand[MAX_IDX_WIDTH-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_IDX_WIDTH-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/avalon_stream_arbiter_if.sv
// Avalon-ST bundle for the arbiter: NUM_IN request streams in, one stream out.
// master = arbiter side, slave = requesters plus downstream sink.
// out_channel exists only with AVALON_STREAM_ARBITER_CHANNEL_EN.
interface avalon_stream_arbiter_if #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 8
`ifdef AVALON_STREAM_ARBITER_CHANNEL_EN
  , parameter int unsigned IDX_WIDTH  = 2
`endif
);

    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN-1:0]            in_ready;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]            in_endofpacket;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_endofpacket;
`ifdef AVALON_STREAM_ARBITER_CHANNEL_EN
    logic [IDX_WIDTH-1:0]         out_channel;

    modport master (
        input  in_valid, in_data, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_endofpacket, out_channel
    );

    modport slave (
        output in_valid, in_data, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_endofpacket, out_channel
    );
`else
    modport master (
        input  in_valid, in_data, in_endofpacket, out_ready,
        output in_ready, out_valid, out_data, out_endofpacket
    );

    modport slave (
        output in_valid, in_data, in_endofpacket, out_ready,
        input  in_ready, out_valid, out_data, out_endofpacket
    );
`endif

endinterface

// File: rtl/avalon_stream_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: next requester after i_last, wrapping.
module rr_priority_picker
    import avalon_stream_pkg::*;
#(
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_IN-1:0]    i_req,
    input  logic [IDX_WIDTH-1:0] i_last,
    output logic                 o_found_c,
    output logic [IDX_WIDTH-1:0] o_idx_c
);

    rr_pick_t w_pick;

    // Search the request vector starting one past the previous winner.
    always_comb begin
        w_pick    = rr_next(MAX_IN'(i_req), 32'(i_last), NUM_IN);
        o_found_c = w_pick.found;
        o_idx_c   = IDX_WIDTH'(w_pick.idx);
    end

endmodule

// File: rtl/avalon_stream_arbiter.sv
// Packet-aware round-robin arbiter sharing one registered Avalon-ST output.
// A grant is held from the first beat until the endofpacket beat is accepted.
// Optional feature macro: AVALON_STREAM_ARBITER_CHANNEL_EN (registered out_channel).
module avalon_stream_arbiter
    import avalon_stream_pkg::*;
#(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_stream_arbiter_if.master bus
);

    localparam int unsigned EXP_IDX_WIDTH = idx_width_for(NUM_IN);

    // Reject configurations the picker and grant register cannot represent.
    if ((NUM_IN < 2) || (NUM_IN > MAX_IN) || (IDX_WIDTH != EXP_IDX_WIDTH)) begin : g_bad_cfg
        $error("avalon_stream_arbiter: NUM_IN must be 2..16 and IDX_WIDTH must be ceil(log2(NUM_IN))");
    end

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_grant;
    logic [IDX_WIDTH-1:0]  w_grant_nxt;
    logic [IDX_WIDTH-1:0]  r_last_grant;
    logic [IDX_WIDTH-1:0]  w_last_grant_nxt;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_eop;
`ifdef AVALON_STREAM_ARBITER_CHANNEL_EN
    logic [IDX_WIDTH-1:0]  r_out_channel;
`endif

    logic                  w_can_load;
    logic                  w_sel_valid;
    logic                  w_sel_eop;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_accept;
    logic                  w_pick_found;
    logic [IDX_WIDTH-1:0]  w_pick_idx;
    logic [DATA_WIDTH-1:0] w_in_data_arr [NUM_IN];

    // Split the flat request data bus into one beat per requester.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_split
        assign w_in_data_arr[gi] = bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_IN    (NUM_IN),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .i_req     (bus.in_valid),
        .i_last    (r_last_grant),
        .o_found_c (w_pick_found),
        .o_idx_c   (w_pick_idx)
    );

    // Output register may take a new beat when empty or being drained.
    always_comb begin
        w_can_load  = !r_out_valid || bus.out_ready;
        w_sel_valid = bus.in_valid[r_grant];
        w_sel_eop   = bus.in_endofpacket[r_grant];
        w_sel_data  = w_in_data_arr[r_grant];
        w_accept    = (r_state == LOCKED) && w_can_load && w_sel_valid;
    end

    // Only the granted requester sees ready, and only while the output can load.
    always_comb begin
        bus.in_ready = '0;
        if ((r_state == LOCKED) && w_can_load) begin
            bus.in_ready[r_grant] = 1'b1;
        end
    end

    // Next-state: arbitrate in IDLE, release the grant on the accepted eop beat.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_grant_nxt      = w_pick_idx;
                    w_last_grant_nxt = w_pick_idx;
                    w_state_nxt      = LOCKED;
                end
            end
            LOCKED: begin
                if (w_accept && w_sel_eop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; last_grant resets to NUM_IN-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_WIDTH'(NUM_IN - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Output stage: load on accept, drop valid once drained, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_eop   <= w_sel_eop;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef AVALON_STREAM_ARBITER_CHANNEL_EN
    // Channel tag travels with the beat it was loaded with.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_channel <= '0;
        end else if (w_accept) begin
            r_out_channel <= r_grant;
        end
    end

    assign bus.out_channel = r_out_channel;
`endif

    assign bus.out_valid       = r_out_valid;
    assign bus.out_data        = r_out_data;
    assign bus.out_endofpacket = r_out_eop;

endmodule
